// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus arbiter.
package regbus_pkg;

  localparam int unsigned REGBUS_ADDRW  = 8;
  localparam int unsigned REGBUS_MAXREQ = 4;
  localparam int unsigned REGBUS_IDXW   = $clog2(REGBUS_MAXREQ);

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    RDATA
  } regbus_state_t;

endpackage

// File: rtl/regbus_pick.sv
// Combinational winner picker: round-robin from a pointer when REGBUS_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module regbus_pick
  import regbus_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]        i_req,
`ifdef REGBUS_ARB_RR_EN
  input  logic [REGBUS_IDXW-1:0] i_ptr,
`endif
  output logic [NREQ-1:0]        o_gnt,
  output logic [REGBUS_IDXW-1:0] o_idx
);

  logic found;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
`ifdef REGBUS_ARB_RR_EN
    // Visit candidates in order ptr, ptr+1, ... wrapping at NREQ; first requester wins.
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!found && i_req[k] && (k == (32'(i_ptr) + i) % NREQ)) begin
          found    = 1'b1;
          o_gnt[k] = 1'b1;
          o_idx    = REGBUS_IDXW'(k);
        end
      end
    end
`else
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && i_req[k]) begin
        found    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = REGBUS_IDXW'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Arbitrates up to four requesters onto a single register-bank port.
// Define REGBUS_ARB_RR_EN for round-robin; default build is fixed priority.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DATAW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_we,
  input  logic [NREQ*REGBUS_ADDRW-1:0] i_addr,
  input  logic [NREQ*DATAW-1:0]    i_wdata,
  output logic [NREQ-1:0]          o_ack,
  output logic [DATAW-1:0]         o_rdata,
  output logic                     o_busy,
  output logic                     o_reg_we,
  output logic [REGBUS_ADDRW-1:0]  o_reg_addr,
  output logic [DATAW-1:0]         o_reg_wdata,
  input  logic [DATAW-1:0]         i_reg_rdata
);

  regbus_state_t state_q, state_d;

  logic [NREQ-1:0]         gnt_q, pick_gnt;
  logic [REGBUS_IDXW-1:0]  pick_idx;
  logic                    we_q, sel_we;
  logic [REGBUS_ADDRW-1:0] addr_q, sel_addr;
  logic [DATAW-1:0]        wdata_q, sel_wdata;
  logic                    latch;

`ifdef REGBUS_ARB_RR_EN
  logic [REGBUS_IDXW-1:0] ptr_q, ptr_d;
`endif

  regbus_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .i_req(i_req),
`ifdef REGBUS_ARB_RR_EN
    .i_ptr(ptr_q),
`endif
    .o_gnt(pick_gnt),
    .o_idx(pick_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == REGBUS_IDXW'(k)) begin
        sel_we    = i_we[k];
        sel_addr  = i_addr[k*REGBUS_ADDRW +: REGBUS_ADDRW];
        sel_wdata = i_wdata[k*DATAW +: DATAW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    o_ack    = '0;
    o_reg_we = 1'b0;
    o_rdata  = '0;
    unique case (state_q)
      ARB: begin
        if (|i_req) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_reg_we = we_q;
        if (we_q) begin
          o_ack   = gnt_q;
          state_d = ARB;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        o_ack   = gnt_q;
        o_rdata = i_reg_rdata;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    // A transaction interrupted by reset must never acknowledge.
    if (i_rst) begin
      o_ack   = '0;
      o_rdata = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        gnt_q   <= pick_gnt;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

`ifdef REGBUS_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (latch) begin
      ptr_d = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Address and data stay on the latched values outside ISSUE so the bank read mux is stable.
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_busy      = (state_q != ARB);

endmodule
